// File: rtl/ascon_perm_ctrl.sv
// Ascon-p permutation sequencer: owns the 320-bit state, steps the datapath UROL rounds
// per clock and serialises S-box LUT writes. Optional counters: ASCON_PERM_CTRL_PERF_CNT_EN.
module ascon_perm_ctrl #(
  parameter int unsigned UROL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid_i,
  output logic        start_ready_o,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output logic        err_o,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [4:0]  cfg_addr_i,
  input  logic [20:0] cfg_data_i,
  output logic [3:0]  dp_round_cnt_o,
  output logic [63:0] dp_x0_o,
  output logic [63:0] dp_x1_o,
  output logic [63:0] dp_x2_o,
  output logic [63:0] dp_x3_o,
  output logic [63:0] dp_x4_o,
  input  logic [63:0] dp_x0_i,
  input  logic [63:0] dp_x1_i,
  input  logic [63:0] dp_x2_i,
  input  logic [63:0] dp_x3_i,
  input  logic [63:0] dp_x4_i,
  output logic        dp_upd_sbox_o,
  output logic [4:0]  dp_sbox_addr_o,
  output logic [20:0] dp_sbox_data_o
`ifdef ASCON_PERM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perm_cnt_o,
  output logic [15:0] cfg_cnt_o
`endif
);

  localparam logic [3:0] STEP = 4'(UROL);

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0][63:0] st_q;
  logic [4:0][63:0] x_in;
  logic [4:0][63:0] dp_in;
  logic [3:0]       cnt_q;
  logic [4:0]       addr_q;
  logic [20:0]      data_q;
  logic             err_q;
  logic             cfg_acc;
  logic             start_acc;
  logic             rounds_ok;
  logic             last_step;

  assign x_in  = {x4_i, x3_i, x2_i, x1_i, x0_i};
  assign dp_in = {dp_x4_i, dp_x3_i, dp_x2_i, dp_x1_i, dp_x0_i};

  // A pending config write always wins arbitration; the start is held off, not dropped.
  always_comb begin
    state_d       = state_q;
    start_ready_o = 1'b0;
    cfg_ready_o   = 1'b0;
    cfg_acc       = 1'b0;
    start_acc     = 1'b0;
    rounds_ok     = (rounds_i != '0) && (rounds_i <= 4'd12) && ((rounds_i % STEP) == '0);
    last_step     = (cnt_q == STEP);
    unique case (state_q)
      IDLE: begin
        cfg_ready_o   = 1'b1;
        start_ready_o = !cfg_valid_i;
        cfg_acc       = cfg_valid_i;
        start_acc     = start_valid_i && !cfg_valid_i;
        if (cfg_acc) begin
          state_d = CFG;
        end else if (start_acc && rounds_ok) begin
          state_d = RUN;
        end
      end
      CFG:  state_d = IDLE;
      RUN:  if (last_step) state_d = DONE;
      DONE: if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_acc && !rounds_ok;
      if (cfg_acc) begin
        addr_q <= cfg_addr_i;
        data_q <= cfg_data_i;
      end
      if (start_acc && rounds_ok) begin
        st_q  <= x_in;
        cnt_q <= rounds_i;
      end else if (state_q == RUN) begin
        st_q  <= dp_in;
        cnt_q <= cnt_q - STEP;
      end
    end
  end

  assign res_valid_o    = (state_q == DONE);
  assign err_o          = err_q;
  assign dp_upd_sbox_o  = (state_q == CFG);
  assign dp_sbox_addr_o = addr_q;
  assign dp_sbox_data_o = data_q;
  assign dp_round_cnt_o = cnt_q;

  assign x0_o    = st_q[0];
  assign x1_o    = st_q[1];
  assign x2_o    = st_q[2];
  assign x3_o    = st_q[3];
  assign x4_o    = st_q[4];
  assign dp_x0_o = st_q[0];
  assign dp_x1_o = st_q[1];
  assign dp_x2_o = st_q[2];
  assign dp_x3_o = st_q[3];
  assign dp_x4_o = st_q[4];

`ifdef ASCON_PERM_CTRL_PERF_CNT_EN
  logic [31:0] perm_cnt_q;
  logic [15:0] cfg_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perm_cnt_q <= '0;
      cfg_cnt_q  <= '0;
    end else begin
      if ((state_q == DONE) && res_ready_i && (perm_cnt_q != '1)) begin
        perm_cnt_q <= perm_cnt_q + 32'd1;
      end
      if (cfg_acc && (cfg_cnt_q != '1)) begin
        cfg_cnt_q <= cfg_cnt_q + 16'd1;
      end
    end
  end

  assign perm_cnt_o = perm_cnt_q;
  assign cfg_cnt_o  = cfg_cnt_q;
`endif

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: two instances (UROL=1 and UROL=2), each driving a stand-in
// datapath whose round function is order-sensitive so the issued round counts are visible.
module tb_ascon_perm_ctrl;

  logic clk;
  logic rst;

  logic [1:0]  start_valid;
  logic [1:0]  res_ready;
  logic [1:0]  cfg_valid;
  logic [3:0]  rounds [2];
  logic [4:0]  cfg_addr [2];
  logic [20:0] cfg_data [2];
  logic [63:0] xi [5];

  wire [1:0]   start_ready;
  wire [1:0]   res_valid;
  wire [1:0]   err;
  wire [1:0]   cfg_ready;
  wire [1:0]   upd;
  wire [63:0]  xo [2][5];
  wire [63:0]  dpo [2][5];
  wire [319:0] dpi [2];
  wire [3:0]   dp_cnt [2];
  wire [4:0]   saddr [2];
  wire [20:0]  sdata [2];
`ifdef ASCON_PERM_CTRL_PERF_CNT_EN
  wire [31:0]  perm_cnt [2];
  wire [15:0]  cfg_cnt [2];
`endif

  int unsigned tests;
  int unsigned fails;

  typedef struct {
    int unsigned  g;
    logic [3:0]   r;
    logic [319:0] seed;
    logic         exp_err;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [319:0] dp_step(input logic [319:0] s, input logic [3:0] c);
    logic [319:0] t;
    logic [63:0]  l;
    t = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      l = s[64*k +: 64];
      t[64*k +: 64] = {l[62:0], l[63]} ^ {56'h9E3779B97F4A7C, c, 4'(k)};
    end
    return t;
  endfunction

  // Expected result: the datapath applied at counts r, r-u, ..., u.
  function automatic logic [319:0] exp_perm(input logic [319:0] s, input logic [3:0] r,
                                            input int unsigned u);
    logic [319:0] t;
    t = s;
    for (int unsigned c = r; c >= u; c -= u) t = dp_step(t, 4'(c));
    return t;
  endfunction

  function automatic logic [319:0] mk_seed(input logic [63:0] b);
    return {b ^ 64'h4, b ^ 64'h3, b ^ 64'h2, b ^ 64'h1, b};
  endfunction

  function automatic logic [319:0] xo_of(input int unsigned g);
    return {xo[g][4], xo[g][3], xo[g][2], xo[g][1], xo[g][0]};
  endfunction

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    ascon_perm_ctrl #(.UROL((g == 0) ? 1 : 2)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start_valid_i  (start_valid[g]),
      .start_ready_o  (start_ready[g]),
      .rounds_i       (rounds[g]),
      .x0_i           (xi[0]),
      .x1_i           (xi[1]),
      .x2_i           (xi[2]),
      .x3_i           (xi[3]),
      .x4_i           (xi[4]),
      .res_valid_o    (res_valid[g]),
      .res_ready_i    (res_ready[g]),
      .x0_o           (xo[g][0]),
      .x1_o           (xo[g][1]),
      .x2_o           (xo[g][2]),
      .x3_o           (xo[g][3]),
      .x4_o           (xo[g][4]),
      .err_o          (err[g]),
      .cfg_valid_i    (cfg_valid[g]),
      .cfg_ready_o    (cfg_ready[g]),
      .cfg_addr_i     (cfg_addr[g]),
      .cfg_data_i     (cfg_data[g]),
      .dp_round_cnt_o (dp_cnt[g]),
      .dp_x0_o        (dpo[g][0]),
      .dp_x1_o        (dpo[g][1]),
      .dp_x2_o        (dpo[g][2]),
      .dp_x3_o        (dpo[g][3]),
      .dp_x4_o        (dpo[g][4]),
      .dp_x0_i        (dpi[g][63:0]),
      .dp_x1_i        (dpi[g][127:64]),
      .dp_x2_i        (dpi[g][191:128]),
      .dp_x3_i        (dpi[g][255:192]),
      .dp_x4_i        (dpi[g][319:256]),
      .dp_upd_sbox_o  (upd[g]),
      .dp_sbox_addr_o (saddr[g]),
      .dp_sbox_data_o (sdata[g])
`ifdef ASCON_PERM_CTRL_PERF_CNT_EN
      ,
      .perm_cnt_o     (perm_cnt[g]),
      .cfg_cnt_o      (cfg_cnt[g])
`endif
    );
    assign dpi[g] = dp_step({dpo[g][4], dpo[g][3], dpo[g][2], dpo[g][1], dpo[g][0]}, dp_cnt[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_x(input logic [319:0] s);
    for (int unsigned k = 0; k < 5; k++) xi[k] = s[64*k +: 64];
  endtask

  task automatic run_perm(input int unsigned gi, input logic [3:0] r, input logic [319:0] seed);
    int unsigned n;
    int unsigned u;
    u = (gi == 0) ? 1 : 2;
    set_x(seed);
    rounds[gi] = r;
    start_valid[gi] = 1'b1;
    #1;
    chk("start_ready at accept", 320'(start_ready[gi]), 320'd1);
    tick();
    start_valid[gi] = 1'b0;
    n = 0;
    while (res_valid[gi] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("result latency", 320'(n), 320'(r / u));
    chk("result state", xo_of(gi), exp_perm(seed, r, u));
    res_ready[gi] = 1'b1;
    #1;
    chk("start_ready in handshake cycle", 320'(start_ready[gi]), 320'd0);
    tick();
    res_ready[gi] = 1'b0;
    chk("res_valid after handshake", 320'(res_valid[gi]), 320'd0);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [20:0] d);
    cfg_valid[0] = 1'b1;
    cfg_addr[0]  = a;
    cfg_data[0]  = d;
    #1;
    chk("cfg_ready at accept", 320'(cfg_ready[0]), 320'd1);
    tick();
    cfg_valid[0] = 1'b0;
    chk("upd_sbox in CFG", 320'(upd[0]), 320'd1);
    chk("sbox addr", 320'(saddr[0]), 320'(a));
    chk("sbox data", 320'(sdata[0]), 320'(d));
    chk("cfg_ready in CFG", 320'(cfg_ready[0]), 320'd0);
    tick();
    chk("upd_sbox after CFG", 320'(upd[0]), 320'd0);
  endtask

  initial begin
    logic [319:0] seed;
    logic [319:0] prev;
    logic [319:0] exp;
    logic         upd_seen;
    int unsigned  n;

    tests = 0;
    fails = 0;
    vecs[0]  = '{0, 4'd0,  mk_seed(64'h1111_0000_0000_0001), 1'b1};
    vecs[1]  = '{0, 4'd13, mk_seed(64'h2222_0000_0000_0002), 1'b1};
    vecs[2]  = '{0, 4'd15, mk_seed(64'h3333_0000_0000_0003), 1'b1};
    vecs[3]  = '{0, 4'd1,  mk_seed(64'h4444_0000_0000_0004), 1'b0};
    vecs[4]  = '{0, 4'd12, mk_seed(64'h5555_0000_0000_0005), 1'b0};
    vecs[5]  = '{1, 4'd7,  mk_seed(64'h6666_0000_0000_0006), 1'b1};
    vecs[6]  = '{1, 4'd0,  mk_seed(64'h7777_0000_0000_0007), 1'b1};
    vecs[7]  = '{1, 4'd13, mk_seed(64'h8888_0000_0000_0008), 1'b1};
    vecs[8]  = '{1, 4'd3,  mk_seed(64'h9999_0000_0000_0009), 1'b1};
    vecs[9]  = '{1, 4'd12, mk_seed(64'hAAAA_0000_0000_000A), 1'b0};
    vecs[10] = '{1, 4'd6,  mk_seed(64'hBBBB_0000_0000_000B), 1'b0};
    vecs[11] = '{1, 4'd2,  mk_seed(64'hCCCC_0000_0000_000C), 1'b0};
    vecs[12] = '{1, 4'd11, mk_seed(64'hDDDD_0000_0000_000D), 1'b1};

    rst = 1'b1;
    start_valid = '0;
    res_ready   = '0;
    cfg_valid   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      rounds[i]   = '0;
      cfg_addr[i] = '0;
      cfg_data[i] = '0;
    end
    set_x('0);
    tick();
    tick();

    // Reset state
    chk("reset state register", xo_of(0), '0);
    chk("reset round count", 320'(dp_cnt[0]), 320'd0);
    chk("reset res_valid", 320'(res_valid[0]), 320'd0);
    chk("reset err", 320'(err[0]), 320'd0);
    chk("reset upd_sbox", 320'(upd[0]), 320'd0);
    rst = 1'b0;
    tick();
    chk("idle start_ready", 320'(start_ready[0]), 320'd1);
    chk("idle cfg_ready", 320'(cfg_ready[0]), 320'd1);

    // p12 of the all-zero state, UROL=1: count sequence and 13-cycle latency
    set_x('0);
    rounds[0] = 4'd12;
    start_valid[0] = 1'b1;
    #1;
    chk("p12 start_ready", 320'(start_ready[0]), 320'd1);
    tick();
    start_valid[0] = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      chk("p12 round count", 320'(dp_cnt[0]), 320'(12 - i));
      chk("p12 res_valid low in RUN", 320'(res_valid[0]), 320'd0);
      tick();
    end
    chk("p12 res_valid at accept+13", 320'(res_valid[0]), 320'd1);
    chk("p12 result", xo_of(0), exp_perm('0, 4'd12, 1));
    res_ready[0] = 1'b1;
    #1;
    chk("p12 start_ready in handshake", 320'(start_ready[0]), 320'd0);
    tick();
    res_ready[0] = 1'b0;
    chk("p12 res_valid after handshake", 320'(res_valid[0]), 320'd0);
    chk("p12 back in IDLE", 320'(start_ready[0]), 320'd1);

    // p6 with result back-pressure
    seed = mk_seed(64'hDEAD_BEEF_00C0_FFEE);
    exp  = exp_perm(seed, 4'd6, 1);
    set_x(seed);
    rounds[0] = 4'd6;
    start_valid[0] = 1'b1;
    tick();
    start_valid[0] = 1'b0;
    for (int unsigned i = 0; i < 6; i++) tick();
    for (int unsigned i = 0; i < 5; i++) begin
      chk("p6 res_valid held", 320'(res_valid[0]), 320'd1);
      chk("p6 result held", xo_of(0), exp);
      tick();
    end
    res_ready[0] = 1'b1;
    tick();
    res_ready[0] = 1'b0;
    chk("p6 res_valid after handshake", 320'(res_valid[0]), 320'd0);
    chk("p6 back in IDLE", 320'(start_ready[0]), 320'd1);

    // Simultaneous config and start: config wins, start accepted two cycles later
    seed = mk_seed(64'h0123_4567_89AB_CDEF);
    set_x(seed);
    rounds[0]      = 4'd12;
    start_valid[0] = 1'b1;
    cfg_valid[0]   = 1'b1;
    cfg_addr[0]    = 5'h1F;
    cfg_data[0]    = 21'h1ABCDE;
    #1;
    chk("arb cfg_ready", 320'(cfg_ready[0]), 320'd1);
    chk("arb start_ready loses", 320'(start_ready[0]), 320'd0);
    tick();
    cfg_valid[0] = 1'b0;
    chk("arb upd_sbox", 320'(upd[0]), 320'd1);
    chk("arb sbox addr", 320'(saddr[0]), 320'h1F);
    chk("arb sbox data", 320'(sdata[0]), 320'h1ABCDE);
    chk("arb start_ready in CFG", 320'(start_ready[0]), 320'd0);
    tick();
    chk("arb start accepted", 320'(start_ready[0]), 320'd1);
    chk("arb upd_sbox back low", 320'(upd[0]), 320'd0);
    tick();
    start_valid[0] = 1'b0;
    upd_seen = 1'b0;
    n = 0;
    while (res_valid[0] !== 1'b1 && n < 40) begin
      if (upd[0] !== 1'b0) upd_seen = 1'b1;
      tick();
      n++;
    end
    chk("arb run latency", 320'(n), 320'd12);
    chk("arb upd_sbox during RUN", 320'(upd_seen), 320'd0);
    chk("arb result", xo_of(0), exp_perm(seed, 4'd12, 1));
    res_ready[0] = 1'b1;
    tick();
    res_ready[0] = 1'b0;

    // Legal and illegal round counts on both UROL builds
    for (int unsigned i = 0; i < 13; i++) begin
      if (vecs[i].exp_err) begin
        prev = xo_of(vecs[i].g);
        set_x(vecs[i].seed);
        rounds[vecs[i].g] = vecs[i].r;
        start_valid[vecs[i].g] = 1'b1;
        #1;
        chk("illegal start_ready", 320'(start_ready[vecs[i].g]), 320'd1);
        tick();
        start_valid[vecs[i].g] = 1'b0;
        chk("illegal err pulse", 320'(err[vecs[i].g]), 320'd1);
        chk("illegal state unchanged", xo_of(vecs[i].g), prev);
        chk("illegal res_valid", 320'(res_valid[vecs[i].g]), 320'd0);
        tick();
        chk("illegal err one cycle", 320'(err[vecs[i].g]), 320'd0);
        chk("illegal stays IDLE", 320'(start_ready[vecs[i].g]), 320'd1);
        chk("illegal res_valid later", 320'(res_valid[vecs[i].g]), 320'd0);
      end else begin
        run_perm(vecs[i].g, vecs[i].r, vecs[i].seed);
        chk("legal no err", 320'(err[vecs[i].g]), 320'd0);
      end
    end

    // Reset in the middle of a p12, start held across the reset
    set_x(mk_seed(64'hFEED_FACE_CAFE_F00D));
    rounds[0] = 4'd12;
    start_valid[0] = 1'b1;
    tick();
    start_valid[0] = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();
    chk("mid-run count before reset", 320'(dp_cnt[0]), 320'd7);
    rst = 1'b1;
    start_valid[0] = 1'b1;
    seed = mk_seed(64'h5A5A_A5A5_0F0F_F0F0);
    set_x(seed);
    tick();
    rst = 1'b0;
    chk("post-reset state", xo_of(0), '0);
    chk("post-reset round count", 320'(dp_cnt[0]), 320'd0);
    chk("post-reset res_valid", 320'(res_valid[0]), 320'd0);
    run_perm(0, 4'd12, seed);

    // Two config writes and two more permutations for the optional counters
    cfg_write(5'h03, 21'h0F00F);
    cfg_write(5'h1C, 21'h12345);
    run_perm(0, 4'd4, mk_seed(64'h1357_9BDF_2468_ACE0));
    run_perm(0, 4'd8, mk_seed(64'h0F1E_2D3C_4B5A_6978));
`ifdef ASCON_PERM_CTRL_PERF_CNT_EN
    chk("perm_cnt", 320'(perm_cnt[0]), 320'd3);
    chk("cfg_cnt", 320'(cfg_cnt[0]), 320'd2);
    chk("perm_cnt idle instance", 320'(perm_cnt[1]), 320'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
